// File: rtl/microwave_controller.sv
// Microwave sequencing FSM: routes keypad digits into the countdown timer and gates
// countdown/magnetron on door state, with pause, resume, cancel and a timed done flag.
//
// state      | meaning
// IDLE       | no time entered, waiting for the first digit
// ENTRY      | digits being loaded into the timer
// COOKING    | timer counting down, magnetron on
// PAUSED     | countdown held by stop or open door
// DONE       | countdown finished, done flag held for DONE_CYCLES
module microwave_controller #(
  parameter int MAX_DIGITS  = 4,
  parameter int DONE_CYCLES = 3
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       key_valid,
  input  logic [3:0] key_data,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic [3:0] timer_data,
  output logic       timer_loadn,
  output logic       timer_clear,
  output logic       timer_enable,
  output logic       magnetron_on,
  output logic       done
);

  localparam int CNT_W  = $clog2(MAX_DIGITS + 1);
  localparam int DONE_W = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_COOKING = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t              state_q, state_nx;
  logic [CNT_W-1:0]    count_q, count_nx;
  logic [DONE_W-1:0]   done_cnt_q, done_cnt_nx;
  logic [3:0]          data_nx;
  logic                loadn_nx, clear_nx, run_nx, done_nx;
  logic                key_ok;

  assign key_ok = key_valid && (key_data <= 4'd9);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      done_cnt_q   <= '0;
      timer_data   <= 4'd0;
      timer_loadn  <= 1'b1;
      timer_clear  <= 1'b0;
      timer_enable <= 1'b0;
      magnetron_on <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_nx;
      count_q      <= count_nx;
      done_cnt_q   <= done_cnt_nx;
      timer_data   <= data_nx;
      timer_loadn  <= loadn_nx;
      timer_clear  <= clear_nx;
      timer_enable <= run_nx;
      magnetron_on <= run_nx;
      done         <= done_nx;
    end
  end

  always_comb begin
    state_nx    = state_q;
    count_nx    = count_q;
    done_cnt_nx = done_cnt_q;
    data_nx     = timer_data;
    loadn_nx    = 1'b1;
    clear_nx    = 1'b0;
    run_nx      = 1'b0;
    done_nx     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_ok) begin
          data_nx  = key_data;
          loadn_nx = 1'b0;
          count_nx = CNT_W'(1);
          state_nx = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (stop) begin
          clear_nx = 1'b1;
          count_nx = '0;
          state_nx = ST_IDLE;
        end else if (start && door_closed && !timer_zero) begin
          run_nx   = 1'b1;
          state_nx = ST_COOKING;
        end else if (key_ok && (count_q < CNT_W'(MAX_DIGITS))) begin
          data_nx  = key_data;
          loadn_nx = 1'b0;
          count_nx = count_q + CNT_W'(1);
        end
      end
      ST_COOKING: begin
        // Staying here needs door_closed at this edge, so the magnetron never runs open.
        if (stop || !door_closed) begin
          state_nx = ST_PAUSED;
        end else if (timer_zero) begin
          done_nx     = 1'b1;
          done_cnt_nx = DONE_W'(DONE_CYCLES - 1);
          state_nx    = ST_DONE;
        end else begin
          run_nx = 1'b1;
        end
      end
      ST_PAUSED: begin
        if (stop) begin
          clear_nx = 1'b1;
          count_nx = '0;
          state_nx = ST_IDLE;
        end else if (start && door_closed) begin
          run_nx   = 1'b1;
          state_nx = ST_COOKING;
        end
      end
      ST_DONE: begin
        if (stop || (done_cnt_q == '0)) begin
          count_nx = '0;
          state_nx = ST_IDLE;
        end else begin
          done_cnt_nx = done_cnt_q - DONE_W'(1);
          done_nx     = 1'b1;
        end
      end
      default: begin
        count_nx = '0;
        state_nx = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_microwave_controller.sv
// Directed bench for microwave_controller: entry, cooking, interlock, cancel,
// priority and asynchronous clear, all with hand-computed expectations.
module tb_microwave_controller;

  logic       clock = 1'b0;
  logic       clear;
  logic       key_valid;
  logic [3:0] key_data;
  logic       start;
  logic       stop;
  logic       door_closed;
  logic       timer_zero;
  logic [3:0] timer_data;
  logic       timer_loadn;
  logic       timer_clear;
  logic       timer_enable;
  logic       magnetron_on;
  logic       done;

  int checks = 0;
  int errors = 0;

  microwave_controller #(.MAX_DIGITS(4), .DONE_CYCLES(3)) dut (
    .clock        (clock),
    .clear        (clear),
    .key_valid    (key_valid),
    .key_data     (key_data),
    .start        (start),
    .stop         (stop),
    .door_closed  (door_closed),
    .timer_zero   (timer_zero),
    .timer_data   (timer_data),
    .timer_loadn  (timer_loadn),
    .timer_clear  (timer_clear),
    .timer_enable (timer_enable),
    .magnetron_on (magnetron_on),
    .done         (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    key_data  = d;
    tick();
    key_valid = 1'b0;
  endtask

  initial begin
    clear = 1'b1; key_valid = 1'b0; key_data = 4'd0; start = 1'b0; stop = 1'b0;
    door_closed = 1'b1; timer_zero = 1'b0;
    tick(); tick();
    chk("rst_data",   timer_data,   0);
    chk("rst_loadn",  timer_loadn,  1);
    chk("rst_clear",  timer_clear,  0);
    chk("rst_enable", timer_enable, 0);
    chk("rst_mag",    magnetron_on, 0);
    chk("rst_done",   done,         0);
    clear = 1'b0;
    tick();

    // entry: 1,3,0,0 back to back, 5th digit and an invalid digit ignored
    press(4'd1);  chk("k1_loadn", timer_loadn, 0); chk("k1_data", timer_data, 1);
    press(4'd3);  chk("k2_loadn", timer_loadn, 0); chk("k2_data", timer_data, 3);
    press(4'd0);  chk("k3_loadn", timer_loadn, 0); chk("k3_data", timer_data, 0);
    press(4'd0);  chk("k4_loadn", timer_loadn, 0); chk("k4_data", timer_data, 0);
    press(4'd7);  chk("k5_loadn", timer_loadn, 1); chk("k5_data", timer_data, 0);
    press(4'd12); chk("bad_loadn", timer_loadn, 1); chk("bad_data", timer_data, 0);
    tick();       chk("idle_loadn", timer_loadn, 1);

    // cook to completion
    start = 1'b1; tick(); start = 1'b0;
    chk("cook_en", timer_enable, 1); chk("cook_mag", magnetron_on, 1); chk("cook_done", done, 0);
    timer_zero = 1'b1; tick(); timer_zero = 1'b0;
    chk("tz_en", timer_enable, 0); chk("tz_mag", magnetron_on, 0); chk("done_c1", done, 1);
    tick(); chk("done_c2", done, 1);
    tick(); chk("done_c3", done, 1);
    tick(); chk("done_c4", done, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("idle_start_en", timer_enable, 0);

    // door interlock
    press(4'd0); chk("d0_data", timer_data, 0); chk("d0_loadn", timer_loadn, 0);
    press(4'd5); chk("d5_data", timer_data, 5);
    start = 1'b1; tick(); start = 1'b0;
    chk("dcook_mag", magnetron_on, 1);
    door_closed = 1'b0; tick();
    chk("open_mag", magnetron_on, 0); chk("open_en", timer_enable, 0);
    start = 1'b1; tick();
    chk("open_start_mag", magnetron_on, 0);
    door_closed = 1'b1; tick(); start = 1'b0;
    chk("resume_mag", magnetron_on, 1); chk("resume_en", timer_enable, 1);
    chk("resume_clr", timer_clear, 0);

    // pause then cancel
    stop = 1'b1; tick();
    chk("pause_mag", magnetron_on, 0); chk("pause_clr", timer_clear, 0);
    tick(); stop = 1'b0;
    chk("cancel_clr", timer_clear, 1);
    tick(); chk("cancel_clr_end", timer_clear, 0);
    press(4'd9); chk("first_loadn", timer_loadn, 0); chk("first_data", timer_data, 9);
    press(4'd1); chk("n2_loadn", timer_loadn, 0);
    press(4'd2); chk("n3_loadn", timer_loadn, 0);
    press(4'd3); chk("n4_loadn", timer_loadn, 0); chk("n4_data", timer_data, 3);
    press(4'd4); chk("n5_loadn", timer_loadn, 1); chk("n5_data", timer_data, 3);

    // priority: stop beats start in ENTRY; timer_zero blocks start
    stop = 1'b1; start = 1'b1; tick(); stop = 1'b0; start = 1'b0;
    chk("pri_clr", timer_clear, 1); chk("pri_en", timer_enable, 0);
    press(4'd2); chk("pri_key_loadn", timer_loadn, 0); chk("pri_key_data", timer_data, 2);
    start = 1'b1; timer_zero = 1'b1; tick();
    chk("tz_start_mag", magnetron_on, 0); chk("tz_start_en", timer_enable, 0);
    timer_zero = 1'b0; tick(); start = 1'b0;
    chk("entry_kept_mag", magnetron_on, 1);

    // stop ends DONE early
    timer_zero = 1'b1; tick(); timer_zero = 1'b0;
    chk("early_done", done, 1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("early_done_end", done, 0);

    // asynchronous clear mid-COOKING
    press(4'd8);
    start = 1'b1; tick(); start = 1'b0;
    chk("pre_clr_mag", magnetron_on, 1);
    #2 clear = 1'b1;
    #1;
    chk("aclr_mag",   magnetron_on, 0);
    chk("aclr_en",    timer_enable, 0);
    chk("aclr_done",  done,         0);
    chk("aclr_loadn", timer_loadn,  1);
    chk("aclr_data",  timer_data,   0);
    tick(); clear = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("aclr_idle_en", timer_enable, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
